coherence_bus_ctrl: RTL



---
 rtl/coherence_bus_ctrl_pkg.sv | 33 +++
 rtl/coherence_bus_ctrl_rr_arbiter2.sv | 26 ++
 rtl/coherence_bus_ctrl.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types and constants for the two-core MSI bus coherence controller.
package coherence_bus_ctrl_pkg;

    localparam int NUM_CORES = 2;
    localparam int ADDR_W    = 13;
    localparam int DATA_W    = 16;

    // Fill source steered to a core's cache on a granted transfer.
    typedef enum logic [1:0] {
        SOURCE_DMEM       = 2'b00,
        SOURCE_OTHER_PROC = 2'b01
    } bus_src_t;

    // Bus ownership state.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        PEER_XFER = 2'b01,
        MEM_XFER  = 2'b10
    } bus_state_t;

    // Per-line MSI state used by the cache controllers.
    typedef enum logic [1:0] {
        BLK_INVALID  = 2'b00,
        BLK_SHARED   = 2'b01,
        BLK_MODIFIED = 2'b10
    } blk_state_t;

    // Index of the other core.
    function automatic logic peer_of(input logic core);
        return ~core;
    endfunction

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter2.sv
// Two-input round-robin arbiter. On a tie the input that did not win last
// time is chosen; the history only advances when the caller commits a grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    output logic       valid_o,
    output logic       win_o
);

    logic last_q;

    assign valid_o = |req_i;
    assign win_o   = (req_i == 2'b11) ? ~last_q : req_i[1];

    // Remember the last committed winner; core 1 at reset so core 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (upd_i && valid_o) begin
            last_q <= win_o;
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Shared-bus coherence controller for two MSI caches: arbitrates the bus,
// snoops the peer on read misses, steers the fill source and forwards
// invalidates to the other core.
module coherence_bus_ctrl
    import coherence_bus_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int TO_W        = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       read_miss,
    input  logic [1:0]       write_miss,
    input  logic [1:0]       invalidate,
    input  logic [1:0]       mem_req,
    input  logic [1:0][12:0] bico,
    input  logic [1:0]       cpu_search_found,
    input  logic [1:0][15:0] send_other_proc_data,
    input  logic             u_rdy,
    output logic [1:0]       grant,
    output logic [1:0]       cpu_search,
    output logic [1:0][12:0] boci,
    output logic [1:0][1:0]  cpu_datasel,
    output logic [1:0][15:0] other_proc_data,
    output logic [1:0]       invalidate_from_other_cpu,
    output logic             bus_err
);

    bus_state_t            state_q;
    logic                  win_q;
    logic                  rd_q;
    logic [TO_W-1:0]       cnt_q;
    logic [1:0]            grant_q;
    logic [1:0][1:0]       datasel_q;
    logic [1:0][15:0]      opd_q;
    logic [1:0]            inv_out_q;
    logic [1:0][12:0]      boci_q;
    logic                  bus_err_q;
    logic [1:0]            pend_q;
    logic [1:0][12:0]      pend_addr_q;

    logic [1:0]            pend_d;
    logic [1:0][12:0]      pend_addr_d;
    logic [1:0]            issue_d;
    logic [1:0][12:0]      issue_addr_d;

    logic                  arb_valid;
    logic                  arb_win;
    logic                  start;
    logic                  start_rd;
    logic                  peer_found;
    logic                  xfer_done;
    logic [1:0]            inv_to;
    logic [1:0][12:0]      addr_to;

    // Arbitration is only committed from IDLE.
    assign start = (state_q == IDLE) && arb_valid;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (read_miss | mem_req),
        .upd_i   (state_q == IDLE),
        .valid_o (arb_valid),
        .win_o   (arb_win)
    );

    assign start_rd   = start && read_miss[arb_win];
    assign peer_found = cpu_search_found[peer_of(arb_win)];

    // Anything addressed to core t originates at the other core.
    assign inv_to  = {invalidate[0] | write_miss[0], invalidate[1] | write_miss[1]};
    assign addr_to = {bico[0], bico[1]};

    // Snoop strobe and address: the snoop overrides the registered invalidate address.
    always_comb begin
        cpu_search = '0;
        if (start_rd) begin
            cpu_search[peer_of(arb_win)] = 1'b1;
        end
        for (int t = 0; t < NUM_CORES; t++) begin
            boci[t] = cpu_search[t] ? addr_to[t] : boci_q[t];
        end
    end

    // Invalidate routing: a snoop on the target core defers the invalidate one cycle.
    always_comb begin
        for (int t = 0; t < NUM_CORES; t++) begin
            issue_d[t]      = 1'b0;
            issue_addr_d[t] = addr_to[t];
            pend_d[t]       = 1'b0;
            pend_addr_d[t]  = pend_addr_q[t];
            if (cpu_search[t]) begin
                pend_d[t] = pend_q[t] | inv_to[t];
                if (inv_to[t]) begin
                    pend_addr_d[t] = addr_to[t];
                end
            end else if (pend_q[t]) begin
                issue_d[t]      = 1'b1;
                issue_addr_d[t] = pend_addr_q[t];
                pend_d[t]       = inv_to[t];
                if (inv_to[t]) begin
                    pend_addr_d[t] = addr_to[t];
                end
            end else if (inv_to[t]) begin
                issue_d[t] = 1'b1;
            end
        end
    end

    // Invalidate output and pending registers, independent of the bus FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_out_q   <= '0;
            boci_q      <= '0;
            pend_q      <= '0;
            pend_addr_q <= '0;
        end else begin
            inv_out_q   <= issue_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            for (int t = 0; t < NUM_CORES; t++) begin
                if (issue_d[t]) begin
                    boci_q[t] <= issue_addr_d[t];
                end
            end
        end
    end

    // A read miss finishes on memory ready; an evict/refill when its level request drops.
    assign xfer_done = rd_q ? u_rdy : ~mem_req[win_q];

    // Bus ownership FSM with registered grant, fill source and peer data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_q     <= 1'b0;
            rd_q      <= 1'b0;
            cnt_q     <= '0;
            grant_q   <= '0;
            datasel_q <= {SOURCE_DMEM, SOURCE_DMEM};
            opd_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    grant_q <= '0;
                    if (start) begin
                        win_q   <= arb_win;
                        cnt_q   <= '0;
                        grant_q <= 2'b01 << arb_win;
                        if (start_rd) begin
                            rd_q <= 1'b1;
                            if (peer_found) begin
                                datasel_q[arb_win] <= SOURCE_OTHER_PROC;
                                opd_q[arb_win]     <= send_other_proc_data[peer_of(arb_win)];
                                state_q            <= PEER_XFER;
                            end else begin
                                datasel_q[arb_win] <= SOURCE_DMEM;
                                state_q            <= MEM_XFER;
                            end
                        end else begin
                            rd_q               <= 1'b0;
                            datasel_q[arb_win] <= SOURCE_DMEM;
                            state_q            <= MEM_XFER;
                        end
                    end
                end
                PEER_XFER: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
                MEM_XFER: begin
                    if (xfer_done) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
                        grant_q   <= '0;
                        bus_err_q <= 1'b1;
                        state_q   <= IDLE;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant                     = grant_q;
    assign cpu_datasel               = datasel_q;
    assign other_proc_data           = opd_q;
    assign invalidate_from_other_cpu = inv_out_q;
    assign bus_err                   = bus_err_q;

endmodule
